// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed common-anode seven-segment driver. One shared decoder
// scans NUM_DIGITS digits. Features: hex glyphs, per-digit decimal points,
// leading-zero suppression, blanking at the start of each slot, and an
// atomic shadow load of the displayed value. All outputs are registered.
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic                    load,
   input  logic                    hex_en,
   input  logic                    lz_blank,
   output logic [6:0]              seg,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
   localparam logic [KW-1:0] K_LAST  = KW'(NUM_DIGITS - 1);

   // Active-low glyph for one nibble; codes 10-15 are blank unless hex is enabled.
   function automatic logic [6:0] decode(input logic [3:0] n, input logic hex);
      logic [6:0] g;
      g = 7'b1111111;
      case (n)
         4'd0:  g = 7'b1000000;
         4'd1:  g = 7'b1111001;
         4'd2:  g = 7'b0100100;
         4'd3:  g = 7'b0110000;
         4'd4:  g = 7'b0011001;
         4'd5:  g = 7'b0010010;
         4'd6:  g = 7'b0000010;
         4'd7:  g = 7'b1111000;
         4'd8:  g = 7'b0000000;
         4'd9:  g = 7'b0010000;
         4'd10: g = hex ? 7'b0001000 : 7'b1111111;
         4'd11: g = hex ? 7'b0000011 : 7'b1111111;
         4'd12: g = hex ? 7'b1000110 : 7'b1111111;
         4'd13: g = hex ? 7'b0100001 : 7'b1111111;
         4'd14: g = hex ? 7'b0000110 : 7'b1111111;
         4'd15: g = hex ? 7'b0001110 : 7'b1111111;
         default: g = 7'b1111111;
      endcase
      return g;
   endfunction

   logic [PW-1:0]           p_q, p_d;
   logic [KW-1:0]           k_q, k_d;
   logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_n_q, dp_n_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    tick_q, tick_d;

   logic [3:0]              nib;
   logic                    nib_dp;
   logic                    zero_above;
   logic                    suppress;
   logic                    lit;

   // Next-state: scan counters, shadow capture, and the output word for the current (p, k).
   always_comb begin
      p_d          = p_q + 1'b1;
      k_d          = k_q;
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      nib          = 4'd0;
      nib_dp       = 1'b0;
      zero_above   = 1'b1;
      suppress     = 1'b0;

      if (p_q == P_LAST) begin
         p_d = '0;
         k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
      end

      if (load) begin
         shadow_val_d = value;
         shadow_dp_d  = dp;
      end

      // Walk from the most significant digit down so zero_above at digit i
      // means nibbles i..NUM_DIGITS-1 are all zero.
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above & (shadow_val_q[4*i +: 4] == 4'd0);
         if (k_q == KW'(i)) begin
            nib      = shadow_val_q[4*i +: 4];
            nib_dp   = shadow_dp_q[i];
            suppress = lz_blank & (i != 0) & zero_above;
         end
      end

      lit = (p_q >= P_BLANK) & ~suppress;

      for (int i = 0; i < NUM_DIGITS; i++) begin
         an_d[i] = ~(lit & (k_q == KW'(i)));
      end
      seg_d  = lit ? decode(nib, hex_en) : 7'b1111111;
      dp_n_d = lit ? ~nib_dp : 1'b1;
      tick_d = (p_q == P_LAST) & (k_q == K_LAST);
   end

   // State and registered outputs; reset blanks the display and restarts at digit 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q          <= '0;
         k_q          <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         seg_q        <= 7'b1111111;
         dp_n_q       <= 1'b1;
         an_q         <= '1;
         tick_q       <= 1'b0;
      end else begin
         p_q          <= p_d;
         k_q          <= k_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         seg_q        <= seg_d;
         dp_n_q       <= dp_n_d;
         an_q         <= an_d;
         tick_q       <= tick_d;
      end
   end

   assign seg        = seg_q;
   assign dp_n       = dp_n_q;
   assign an         = an_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4-cycle slots, 1 blank cycle).
// The driver computes the expected output word from a cycle-count model and
// queues it; a monitor pops one entry per clock and compares.
module tb_seg7_scan_driver;

   localparam int N = 4;
   localparam int R = 4;
   localparam int B = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [4*N-1:0] value;
   logic [N-1:0]  dp;
   logic          load, hex_en, lz_blank;
   logic [6:0]    seg;
   logic          dp_n;
   logic [N-1:0]  an;
   logic          frame_tick;

   seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
      .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
      .hex_en(hex_en), .lz_blank(lz_blank),
      .seg(seg), .dp_n(dp_n), .an(an), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0]   seg;
      logic         dp_n;
      logic [N-1:0] an;
      logic         tick;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   started = 1'b0;

   // Reference state: cycles elapsed since reset plus the shadow copy.
   int          t;
   logic [15:0] sv;
   logic [3:0]  sdp;

   logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic [15:0] PATTERNS [5] = '{16'h1234, 16'hABCF, 16'h0050, 16'h0000, 16'h0300};

   function automatic exp_t model_out();
      exp_t        e;
      int          p, k;
      logic [3:0]  n;
      logic [15:0] upper;
      bit          off;
      p     = t % R;
      k     = (t / R) % N;
      upper = sv >> (4 * k);
      n     = upper[3:0];
      off   = (p < B) || (lz_blank && k != 0 && upper == 16'h0);
      if (off) begin
         e.seg  = 7'b1111111;
         e.an   = 4'b1111;
         e.dp_n = 1'b1;
      end else begin
         e.seg  = (n >= 4'd10 && !hex_en) ? 7'b1111111 : GLYPH[n];
         e.an   = 4'b1111;
         e.an[k] = 1'b0;
         e.dp_n = ~sdp[k];
      end
      e.tick = (p == R - 1) && (k == N - 1);
      return e;
   endfunction

   task automatic check_reset(input string name);
      vectors++;
      if ({seg, dp_n, an, frame_tick} !== {7'b1111111, 1'b1, 4'b1111, 1'b0}) begin
         miscompares++;
         $display("FAIL %s: got seg=%b dp_n=%b an=%b tick=%b, expected seg=1111111 dp_n=1 an=1111 tick=0",
                  name, seg, dp_n, an, frame_tick);
      end
   endtask

   // Asynchronous reset mid-slot: outputs must go idle before the next edge.
   task automatic do_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      #1 check_reset("reset_async");
      @(posedge clk);
      #2 rst = 1'b0;
      t   = 0;
      sv  = '0;
      sdp = '0;
   endtask

   // Monitor: one expected word per clock while out of reset.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (started && !rst) begin
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got seg=%b an=%b, expected a queued entry", seg, an);
         end else begin
            e = q.pop_front();
            if ({seg, dp_n, an, frame_tick} !== e) begin
               miscompares++;
               $display("FAIL scan_output t=%0t: got seg=%b dp_n=%b an=%b tick=%b, expected seg=%b dp_n=%b an=%b tick=%b",
                        $time, seg, dp_n, an, frame_tick, e.seg, e.dp_n, e.an, e.tick);
            end
         end
      end
   end

   initial begin
      rst      = 1'b1;
      value    = '0;
      dp       = '0;
      load     = 1'b0;
      hex_en   = 1'b0;
      lz_blank = 1'b0;
      #3 check_reset("reset_initial");
      repeat (3) @(posedge clk);
      #2 rst  = 1'b0;
      t   = 0;
      sv  = '0;
      sdp = '0;
      started = 1'b1;

      for (int c = 0; c < 4000; c++) begin
         if (c > 0 && (c % 700) == 350) do_reset();
         @(negedge clk);
         load = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 1) == 0)
            value = PATTERNS[$urandom_range(0, 4)];
         else
            value = 16'($urandom);
         dp = 4'($urandom);
         if ($urandom_range(0, 63) == 0) hex_en   = ~hex_en;
         if ($urandom_range(0, 63) == 0) lz_blank = ~lz_blank;
         q.push_back(model_out());
         if (load) begin
            sv  = value;
            sdp = dp;
         end
         t++;
      end

      @(posedge clk);
      #2;
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed seven-segment display driver for the front-panel display. It replaces per-digit combinational BCD decoding with a single shared decoder that scans NUM_DIGITS common-anode digits. It adds hexadecimal glyphs, per-digit decimal points, leading-zero suppression, inter-digit ghost blanking, and an atomic load of the displayed value. It sits between the vending controller (credit/price/change values) and the board's anode/segment pins.

## Interface
- NUM_DIGITS, 4: digits scanned; legal 1..8.
- REFRESH_DIV, 100000: clk cycles per digit slot; legal ≥ 2.
- BLANK_CYCLES, 1000: cycles at slot start with all anodes off; legal 0..REFRESH_DIV-1.

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- value  in  4*NUM_DIGITS  digit nibbles; [3:0] = digit 0 (rightmost).
- dp  in  NUM_DIGITS  decimal point request per digit, active-high.
- load  in  1  when high at a clk edge, shadow registers capture value and dp.
- hex_en  in  1  1: codes 10–15 show A b C d E F; 0: codes 10–15 blank.
- lz_blank  in  1  1: suppress leading zeros.
- seg  out  7  active-low segments, seg[6:0] = {g,f,e,d,c,b,a}.
- dp_n  out  1  active-low decimal point.
- an  out  NUM_DIGITS  active-low anode enables, an[i] = digit i.
- frame_tick  out  1  one-cycle pulse at end of each full scan.

## Operation
- State: prescaler p (0..REFRESH_DIV-1), digit index k (0..NUM_DIGITS-1), shadow_val, shadow_dp.
- p increments each cycle. At p = REFRESH_DIV-1, p returns to 0 and k advances. After NUM_DIGITS-1, k wraps to 0.
- Shadow registers load on any edge with load=1. The display uses only shadow contents, so changes to value/dp without load have no effect.
- Decode of nibble n = shadow_val[4k+3:4k], active-low:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001.
  - 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000.
  - With hex_en=1: 10:0001000, 11:0000011, 12:1000110, 13:0100001, 14:0000110, 15:0001110.
  - With hex_en=0, codes 10–15 give 1111111.
- Leading-zero suppression: digit k is suppressed when lz_blank=1, k≠0, and all shadow nibbles k..NUM_DIGITS-1 equal 0. Digit 0 is never suppressed.
- Per-slot drive:
  - p < BLANK_CYCLES, or digit suppressed: an = all 1s, seg = 1111111, dp_n = 1.
  - Otherwise: an = all 1s except an[k]=0, seg = decode(n), dp_n = ~shadow_dp[k].
- frame_tick = 1 for the single cycle in which p = REFRESH_DIV-1 and k = NUM_DIGITS-1.
- hex_en and lz_blank are live, not shadowed. They affect output on the next registered update.

## Timing
- Reset (async, immediate on rst rise):
  - p=0, k=0, shadow_val=0, shadow_dp=0.
  - an=all 1s, seg=1111111, dp_n=1, frame_tick=0.
- First edge after reset release starts slot 0 with k=0.
- an, seg, dp_n, and frame_tick are registered. Each reflects the (p, k, shadow, hex_en, lz_blank) values present at the previous edge, giving a one-cycle latency.
- load→display: shadow updates at edge E. The new glyph appears at edge E+1 if the current slot is past blanking.
- Slot period = REFRESH_DIV cycles; frame period = NUM_DIGITS·REFRESH_DIV cycles.
- rst asserted mid-slot or mid-frame: all outputs go to reset values without waiting for clk, and the scan restarts at digit 0.
- load and slot boundary on the same edge: the new slot uses the newly loaded shadow.
- NUM_DIGITS=1: k stays 0 and frame_tick pulses every REFRESH_DIV cycles.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
- Reset: run 7 cycles, then assert rst between edges → an=1111, seg=1111111, dp_n=1 immediately. After release the first lit slot is digit 0; frame_tick first pulses on the 16th cycle.
- Decimal scan: load value=16'h1234, dp=4'b0010, hex_en=0. Per slot, after 1 blank cycle:
  - an=1110, seg=0011001.
  - an=1101, seg=0110000, dp_n=0.
  - an=1011, seg=0100100.
  - an=0111, seg=1111001.
- Hex mode: load 16'hABCF with hex_en=1 → slots show 0001110, 1000110, 0000011, 0001000. Toggle hex_en=0 → all four slots seg=1111111.
- Leading zeros: load 16'h0050, lz_blank=1 → digits 3 and 2 keep an all 1s; digit 1 shows 0010010; digit 0 shows 1000000. Load 0 → only digit 0 lit (1000000). With lz_blank=0, all four digits show 0.
- Shadow hold: change value with load=0 for a full frame → outputs unchanged. Pulse load one cycle → new glyph on the next lit cycle.
- Ghost blanking: at every p=0 cycle, an=1111 and seg=1111111. Over 20 frames, frame_tick pulses exactly once per 16 cycles.
